texture_load_ctrl: RTL and testbench

Sequences the power-up texture download that fills the sprite renderer's bird and pipe texture RAMs. On a start pulse it issues burst read requests to the SDRAM read port in `bird_load_clk` domain, streams the returned words into the bird write port (5250 words), then into the pipe write port (first 4000 words only), and flags completion. It sits between the SDRAM controller read port and the sprite renderer load interface, and owns all load addresses and strobes.

---
 rtl/texture_load_ctrl.sv | 177 +++++++++++++++++
 tb/tb_texture_load_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/texture_load_ctrl.sv
// Power-up texture download sequencer: bursts SDRAM reads into the bird RAM,
// then into the pipe RAM, and flags completion.
module texture_load_ctrl #(
    parameter int unsigned BIRD_WORDS = 5250,
    parameter int unsigned PIPE_WORDS = 4000,
    parameter logic [23:0] BIRD_BASE  = 24'h000000,
    parameter logic [23:0] PIPE_BASE  = 24'h002000,
    parameter int unsigned BURST_LEN  = 256,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic        bird_load_clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        rd_req,
    output logic [23:0] rd_addr,
    output logic [8:0]  rd_len,
    input  logic        rd_ack,
    input  logic        rd_valid,
    input  logic [15:0] rd_data,
    output logic        bird_load_en,
    output logic [12:0] bird_load_addr,
    output logic [15:0] bird_load_data,
    output logic        pipe_load_en,
    output logic [15:0] pipe_load_addr,
    output logic        busy,
    output logic        load_done
);

    localparam int unsigned ADDR_W  = 24;
    localparam int unsigned LEN_W   = 9;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned BADDR_W = 13;
    localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, B_REQ, B_DATA, P_REQ, P_DATA, DONE} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    word_cnt, word_nxt;
    logic [LEN_W-1:0]    beat_cnt, beat_nxt;
    logic [TO_W-1:0]     idle_cnt, idle_nxt;
    logic [CNT_W-1:0]    remain;
    logic                enter_req, retry, in_bird, to_bird;
    logic                req_nxt, busy_nxt, done_nxt;
    logic                bird_en_nxt, pipe_en_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [LEN_W-1:0]    len_nxt;
    logic [BADDR_W-1:0]  bird_addr_nxt;
    logic [CNT_W-1:0]    pipe_addr_nxt;
    logic [15:0]         data_nxt;

    always_ff @(posedge bird_load_clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            word_cnt       <= '0;
            beat_cnt       <= '0;
            idle_cnt       <= '0;
            rd_req         <= 1'b0;
            rd_addr        <= '0;
            rd_len         <= '0;
            bird_load_en   <= 1'b0;
            bird_load_addr <= '0;
            bird_load_data <= '0;
            pipe_load_en   <= 1'b0;
            pipe_load_addr <= '0;
            busy           <= 1'b0;
            load_done      <= 1'b0;
        end else begin
            state          <= state_nxt;
            word_cnt       <= word_nxt;
            beat_cnt       <= beat_nxt;
            idle_cnt       <= idle_nxt;
            rd_req         <= req_nxt;
            rd_addr        <= addr_nxt;
            rd_len         <= len_nxt;
            bird_load_en   <= bird_en_nxt;
            bird_load_addr <= bird_addr_nxt;
            bird_load_data <= data_nxt;
            pipe_load_en   <= pipe_en_nxt;
            pipe_load_addr <= pipe_addr_nxt;
            busy           <= busy_nxt;
            load_done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        word_nxt      = word_cnt;
        beat_nxt      = beat_cnt;
        idle_nxt      = idle_cnt;
        done_nxt      = load_done;
        addr_nxt      = rd_addr;
        len_nxt       = rd_len;
        bird_en_nxt   = 1'b0;
        pipe_en_nxt   = 1'b0;
        bird_addr_nxt = bird_load_addr;
        pipe_addr_nxt = pipe_load_addr;
        data_nxt      = bird_load_data;
        enter_req     = 1'b0;
        retry         = 1'b0;
        to_bird       = 1'b0;
        remain        = '0;
        in_bird       = (state == B_DATA);

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    word_nxt  = '0;
                    done_nxt  = 1'b0;
                    state_nxt = B_REQ;
                    enter_req = 1'b1;
                end
            end
            B_REQ, P_REQ: begin
                if (rd_ack) begin
                    beat_nxt  = rd_len;
                    idle_nxt  = '0;
                    state_nxt = (state == B_REQ) ? B_DATA : P_DATA;
                end
            end
            B_DATA, P_DATA: begin
                if (rd_valid && beat_cnt != '0) begin
                    if (in_bird) begin
                        bird_en_nxt   = 1'b1;
                        bird_addr_nxt = BADDR_W'(word_cnt);
                    end else begin
                        pipe_en_nxt   = 1'b1;
                        pipe_addr_nxt = word_cnt;
                    end
                    data_nxt = rd_data;
                    word_nxt = word_cnt + CNT_W'(1);
                    beat_nxt = beat_cnt - LEN_W'(1);
                    idle_nxt = '0;
                    if (word_nxt == (in_bird ? CNT_W'(BIRD_WORDS) : CNT_W'(PIPE_WORDS))) begin
                        if (in_bird) begin
                            word_nxt  = '0;
                            state_nxt = P_REQ;
                            enter_req = 1'b1;
                        end else begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end
                    end else if (beat_cnt == LEN_W'(1)) begin
                        state_nxt = in_bird ? B_REQ : P_REQ;
                        enter_req = 1'b1;
                    end
                end else if (!rd_valid) begin
                    // Stalled burst: re-request only the beats still outstanding
                    if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
                        state_nxt = in_bird ? B_REQ : P_REQ;
                        enter_req = 1'b1;
                        retry     = 1'b1;
                    end else begin
                        idle_nxt = idle_cnt + TO_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (enter_req) begin
            to_bird  = (state_nxt == B_REQ);
            addr_nxt = (to_bird ? BIRD_BASE : PIPE_BASE) + ADDR_W'(word_nxt);
            remain   = (to_bird ? CNT_W'(BIRD_WORDS) : CNT_W'(PIPE_WORDS)) - word_nxt;
            if (retry) begin
                len_nxt = beat_cnt;
            end else if (remain > CNT_W'(BURST_LEN)) begin
                len_nxt = LEN_W'(BURST_LEN);
            end else begin
                len_nxt = LEN_W'(remain);
            end
        end

        req_nxt  = (state_nxt == B_REQ) || (state_nxt == P_REQ);
        busy_nxt = (state_nxt != IDLE) && (state_nxt != DONE);
    end

endmodule

// File: tb/tb_texture_load_ctrl.sv
// Scoreboard bench for texture_load_ctrl: SDRAM read-port model feeds bursts,
// a monitor pops expected requests and RAM writes from queues and compares.
module tb_texture_load_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, rd_ack, rd_valid;
    logic [15:0] rd_data;
    logic        rd_req, bird_load_en, pipe_load_en, busy, load_done;
    logic [23:0] rd_addr;
    logic [8:0]  rd_len;
    logic [12:0] bird_load_addr;
    logic [15:0] bird_load_data, pipe_load_addr;

    always #5 clk = ~clk;

    texture_load_ctrl dut (
        .bird_load_clk (clk),
        .rst_n         (rst_n),
        .start         (start),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_len        (rd_len),
        .rd_ack        (rd_ack),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .bird_load_en  (bird_load_en),
        .bird_load_addr(bird_load_addr),
        .bird_load_data(bird_load_data),
        .pipe_load_en  (pipe_load_en),
        .pipe_load_addr(pipe_load_addr),
        .busy          (busy),
        .load_done     (load_done)
    );

    int n_pass = 0;
    int n_total = 0;
    logic [32:0] req_q[$];
    logic [31:0] bird_q[$];
    logic [31:0] pipe_q[$];
    logic [15:0] bird_mem [0:5249];
    logic [15:0] pipe_mem [0:3999];
    int bird_cnt = 0, pipe_cnt = 0, acc_cnt = 0, cyc = 0, t_611 = -1, burst_idx = 0;
    int stall_burst = -1, stall_after = 0, hold_burst = -1, extra_burst = -1;
    logic spur_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic build_expect(input bit with_stall);
        int rem;
        for (int i = 0; i < 21; i++) begin
            rem = 5250 - i * 256;
            req_q.push_back({24'(i * 256), 9'(rem > 256 ? 256 : rem)});
            if (with_stall && i == 2) req_q.push_back({24'd612, 9'd156});
        end
        for (int i = 0; i < 16; i++) begin
            rem = 4000 - i * 256;
            req_q.push_back({24'h002000 + 24'(i * 256), 9'(rem > 256 ? 256 : rem)});
        end
        for (int i = 0; i < 5250; i++) bird_q.push_back({16'(i), 16'(i)});
        for (int i = 0; i < 4000; i++) pipe_q.push_back({16'(i), 16'(32'h2000 + i)});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && load_done !== 1'b1; k++) @(negedge clk);
    endtask

    task automatic wait_pipe(input int base, input int n, input int budget);
        for (int k = 0; k < budget && (pipe_cnt - base) < n; k++) @(negedge clk);
        chk("wait_pipe_words", 32'((pipe_cnt - base) >= n), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_req"}, 32'(rd_req), 0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
        chk({tag, "_rd_len"}, 32'(rd_len), 0);
        chk({tag, "_bird_en"}, 32'(bird_load_en), 0);
        chk({tag, "_bird_addr"}, 32'(bird_load_addr), 0);
        chk({tag, "_data"}, 32'(bird_load_data), 0);
        chk({tag, "_pipe_en"}, 32'(pipe_load_en), 0);
        chk({tag, "_pipe_addr"}, 32'(pipe_load_addr), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_load_done"}, 32'(load_done), 0);
    endtask

    // SDRAM read-port model: inputs change 1 time unit after the rising edge
    initial begin : sdram
        logic [23:0] cur_addr;
        int cur_len, wait_n, nbeats;
        rd_ack = 1'b0; rd_valid = 1'b0; rd_data = '0;
        forever begin
            @(posedge clk); #1;
            rd_valid = 1'b0;
            if (rst_n && rd_req) begin
                cur_addr = rd_addr;
                cur_len  = int'(rd_len);
                wait_n   = (burst_idx == hold_burst) ? 51 : 3;
                for (int k = 1; k < wait_n && rst_n; k++) begin @(posedge clk); #1; end
                if (rst_n) begin
                    rd_ack = 1'b1;
                    @(posedge clk); #1 rd_ack = 1'b0;
                    @(posedge clk); #1;
                    nbeats = (burst_idx == extra_burst) ? cur_len + 1 : cur_len;
                    if (burst_idx == stall_burst) nbeats = stall_after;
                    for (int b = 0; b < nbeats && rst_n; b++) begin
                        rd_valid = 1'b1;
                        rd_data  = 16'(cur_addr + 24'(b));
                        @(posedge clk); #1;
                    end
                    rd_valid = 1'b0;
                    burst_idx++;
                end
                rd_ack = 1'b0;
            end else if (spur_en) begin
                rd_valid = 1'b1;
                rd_data  = 16'hBEEF;
            end
        end
    end

    initial begin : monitor
        logic [31:0] e;
        logic [32:0] r;
        logic        prev_req, prev_acc;
        logic [23:0] prev_addr;
        logic [8:0]  prev_len;
        prev_req = 1'b0; prev_acc = 1'b0; prev_addr = '0; prev_len = '0;
        forever begin
            @(negedge clk);
            if (bird_load_en || pipe_load_en)
                chk("en_exclusive", 32'(bird_load_en & pipe_load_en), 0);
            if (bird_load_en) begin
                if (bird_q.size() == 0) chk("bird_unexpected", 32'(bird_load_addr), 32'hFFFF_FFFF);
                else begin
                    e = bird_q.pop_front();
                    chk("bird_addr", 32'(bird_load_addr), 32'(e[31:16]));
                    chk("bird_data", 32'(bird_load_data), 32'(e[15:0]));
                end
                if (bird_load_addr < 13'd5250) bird_mem[bird_load_addr] = bird_load_data;
                if (bird_load_addr == 13'd611) t_611 = cyc;
                bird_cnt++;
            end
            if (pipe_load_en) begin
                if (pipe_q.size() == 0) chk("pipe_unexpected", 32'(pipe_load_addr), 32'hFFFF_FFFF);
                else begin
                    e = pipe_q.pop_front();
                    chk("pipe_addr", 32'(pipe_load_addr), 32'(e[31:16]));
                    chk("pipe_data", 32'(bird_load_data), 32'(e[15:0]));
                end
                if (pipe_load_addr < 16'd4000) pipe_mem[12'(pipe_load_addr)] = bird_load_data;
                pipe_cnt++;
            end
            if (rd_req && !prev_req && rd_addr == 24'd612 && t_611 >= 0)
                chk("timeout_gap", 32'(cyc - t_611), 32'd1024);
            if (prev_acc) chk("rd_req_fall", 32'(rd_req), 0);
            else if (rd_req && prev_req) begin
                chk("rd_addr_hold", 32'(rd_addr), 32'(prev_addr));
                chk("rd_len_hold", 32'(rd_len), 32'(prev_len));
            end
            if (rd_req && rd_ack) begin
                acc_cnt++;
                if (req_q.size() == 0) chk("req_unexpected", 32'(rd_addr), 32'hFFFF_FFFF);
                else begin
                    r = req_q.pop_front();
                    chk("req_addr", 32'(rd_addr), 32'(r[32:9]));
                    chk("req_len", 32'(rd_len), 32'(r[8:0]));
                end
                chk("busy_in_req", 32'(busy), 1);
                chk("done_low_in_req", 32'(load_done), 0);
            end
            prev_req  = rd_req;
            prev_acc  = rd_req & rd_ack;
            prev_addr = rd_addr;
            prev_len  = rd_len;
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int b0, p0, a0;
        rst_n = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");

        // Spurious beats while idle
        @(posedge clk); #1 rst_n = 1'b1; spur_en = 1'b1;
        repeat (4) @(posedge clk);
        #1 spur_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_bird_cnt", 32'(bird_cnt), 0);
        chk("idle_pipe_cnt", 32'(pipe_cnt), 0);
        chk("idle_busy", 32'(busy), 0);

        // Run 1: extra 257th beat, stall in bird burst 3, ack withheld on one pipe burst
        extra_burst = 0; stall_burst = 2; stall_after = 100; hold_burst = 30;
        build_expect(1'b1);
        pulse_start();
        @(negedge clk);
        chk("start_rd_req", 32'(rd_req), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_rd_addr", 32'(rd_addr), 0);
        chk("start_rd_len", 32'(rd_len), 256);
        wait_done(40000);
        chk("run1_load_done", 32'(load_done), 1);
        repeat (2) @(negedge clk);
        chk("run1_busy_done", 32'(busy), 0);
        chk("run1_bird_cnt", 32'(bird_cnt), 5250);
        chk("run1_pipe_cnt", 32'(pipe_cnt), 4000);
        chk("run1_bursts", 32'(acc_cnt), 38);
        chk("run1_req_left", 32'(req_q.size()), 0);
        chk("run1_bird_left", 32'(bird_q.size()), 0);
        chk("run1_pipe_left", 32'(pipe_q.size()), 0);
        chk("bird_1750", 32'(bird_mem[1750]), 32'h06D6);
        chk("bird_5249", 32'(bird_mem[5249]), 32'h1481);
        chk("pipe_0", 32'(pipe_mem[0]), 32'h2000);
        chk("pipe_3999", 32'(pipe_mem[3999]), 32'h2F9F);

        // Spurious beats in DONE
        @(posedge clk); #1 spur_en = 1'b1;
        repeat (5) @(posedge clk);
        #1 spur_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_bird_cnt", 32'(bird_cnt), 5250);
        chk("done_pipe_cnt", 32'(pipe_cnt), 4000);
        chk("done_hold", 32'(load_done), 1);

        // Run 2: start ignored in pipe phase, then reset at pipe word 2000
        extra_burst = -1; stall_burst = -1; hold_burst = -1;
        build_expect(1'b0);
        p0 = pipe_cnt;
        pulse_start();
        wait_pipe(p0, 1000, 20000);
        pulse_start();
        @(negedge clk);
        chk("ignored_start_busy", 32'(busy), 1);
        chk("ignored_start_done", 32'(load_done), 0);
        wait_pipe(p0, 2000, 20000);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("midreset");
        b0 = bird_cnt; p0 = pipe_cnt; a0 = acc_cnt;
        repeat (4) @(negedge clk);
        chk("reset_no_bird", 32'(bird_cnt), 32'(b0));
        chk("reset_no_pipe", 32'(pipe_cnt), 32'(p0));
        req_q.delete(); bird_q.delete(); pipe_q.delete();

        // Run 3: fresh download from bird address 0
        @(posedge clk); #1 rst_n = 1'b1;
        build_expect(1'b0);
        pulse_start();
        @(negedge clk);
        chk("restart_rd_req", 32'(rd_req), 1);
        chk("restart_rd_addr", 32'(rd_addr), 0);
        chk("restart_rd_len", 32'(rd_len), 256);
        wait_done(40000);
        chk("run3_load_done", 32'(load_done), 1);
        repeat (2) @(negedge clk);
        chk("run3_bird_cnt", 32'(bird_cnt - b0), 5250);
        chk("run3_pipe_cnt", 32'(pipe_cnt - p0), 4000);
        chk("run3_bursts", 32'(acc_cnt - a0), 37);
        chk("run3_req_left", 32'(req_q.size()), 0);
        chk("run3_bird_left", 32'(bird_q.size()), 0);
        chk("run3_pipe_left", 32'(pipe_q.size()), 0);
        chk("run3_busy", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
